// File: rtl/dc_sram_like.sv
// rtl/dc_sram_like.sv - EX->MEM data-access stage driving an sram-like data bus
//
// Registers the EX-stage memory request and issues it on the req/addr_ok/data_ok
// bus with at most one transaction outstanding. The stage holds the pipeline
// through stallreq_for_dc until the access completes, then hands the load word to
// MEM next to the registered passthrough bus. A flushed transaction is drained to
// its data_ok and is never withdrawn from the bus.
//
// Optional feature macro: DC_ADDR_MAP_EN (kseg0/kseg1 -> physical address map).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             exception/eret flush, clears the stage register
//   stall[7:0]        pipeline stall bus, 1 = stop; [5] EX->DC, [6] DC->MEM
//   ex_to_dc_bus      pipeline fields from EX, forwarded as dc_to_mem_bus
//   ex_mem_en/wen     access valid / byte write enables (0 = load)
//   ex_mem_addr/wdata virtual byte address / lane-aligned store data
//   ex_except         exception already flagged, suppresses the access
//   dc_to_mem_bus     registered ex_to_dc_bus
//   dc_rdata          load word for MEM, held until DC->MEM advances
//   stallreq_for_dc   access not yet complete
//   data_req/wr/size/addr/wdata  request side of the data bus
//   data_addr_ok/data_ok/rdata   accept / response side of the data bus

module dc_sram_like #(
    parameter int DC_TO_MEM_WD = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [7:0]              stall,
    input  logic [DC_TO_MEM_WD-1:0] ex_to_dc_bus,
    input  logic                    ex_mem_en,
    input  logic [3:0]              ex_mem_wen,
    input  logic [31:0]             ex_mem_addr,
    input  logic [31:0]             ex_mem_wdata,
    input  logic                    ex_except,
    output logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
    output logic [31:0]             dc_rdata,
    output logic                    stallreq_for_dc,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [31:0]             data_addr,
    output logic [31:0]             data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [31:0]             data_rdata
);

    localparam logic STOP = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t state, state_nxt;
    logic   cancel, cancel_nxt;
    logic   done;
    logic   issue, complete, rdata_we;

    logic [DC_TO_MEM_WD-1:0] bus_r;
    logic                    en_r, except_r;
    logic [3:0]              wen_r;
    logic [31:0]             addr_r, wdata_r;

    logic                    wr_q;
    logic [1:0]              size_q;
    logic [31:0]             addr_q, wdata_q;

    logic [1:0]              iss_size;
    logic [31:0]             iss_addr, phys_addr;
    logic                    acc;
    logic                    reg_bubble, reg_load, reg_update;

    logic                    unused_stall;
    assign unused_stall = ^{stall[7], stall[4:0]};

    // Stage register: flush and bubble both clear it, so any update means the
    // instruction that was here has left the stage.
    assign reg_bubble = (stall[5] == STOP) && (stall[6] != STOP);
    assign reg_load   = (stall[5] != STOP);
    assign reg_update = flush || reg_bubble || reg_load;

    always_ff @(posedge clk) begin
        if (rst || flush || reg_bubble) begin
            bus_r    <= '0;
            en_r     <= 1'b0;
            wen_r    <= 4'd0;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            except_r <= 1'b0;
        end else if (reg_load) begin
            bus_r    <= ex_to_dc_bus;
            en_r     <= ex_mem_en;
            wen_r    <= ex_mem_wen;
            addr_r   <= ex_mem_addr;
            wdata_r  <= ex_mem_wdata;
            except_r <= ex_except;
        end
    end

    assign dc_to_mem_bus = bus_r;
    assign acc           = en_r && !except_r;

    // Loads always fetch the aligned word; MEM picks the bytes out itself.
    always_comb begin
        iss_size = 2'd2;
        iss_addr = {addr_r[31:2], 2'b00};
        if (wen_r != 4'd0) begin
            iss_addr = addr_r;
            case (wen_r)
                4'b0001, 4'b0010, 4'b0100, 4'b1000:                   iss_size = 2'd0;
                4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100: iss_size = 2'd1;
                default:                                              iss_size = 2'd2;
            endcase
        end
    end

`ifdef DC_ADDR_MAP_EN
    // kseg0/kseg1 are unmapped windows onto the low 512 MiB.
    assign phys_addr = (iss_addr[31:30] == 2'b10) ? {3'b000, iss_addr[28:0]} : iss_addr;
`else
    assign phys_addr = iss_addr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cancel <= 1'b0;
        end else begin
            state  <= state_nxt;
            cancel <= cancel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cancel_nxt = cancel;
        issue      = 1'b0;
        complete   = 1'b0;
        rdata_we   = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc && !done) begin
                    state_nxt = S_REQ;
                    issue     = 1'b1;
                end
            end
            S_REQ: begin
                if (flush) cancel_nxt = 1'b1;
                if (data_addr_ok) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush) cancel_nxt = 1'b1;
                if (data_data_ok) begin
                    cancel_nxt = 1'b0;
                    // A flush landing on the response cycle also discards it.
                    if (cancel || flush) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DONE;
                        complete  = 1'b1;
                        rdata_we  = !wr_q;
                    end
                end
            end
            S_DONE: begin
                if (stall[6] != STOP) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Marks the access held in the stage register as already performed, so a
    // held instruction is never issued twice.
    always_ff @(posedge clk) begin
        if (rst || reg_update) begin
            done <= 1'b0;
        end else if (complete) begin
            done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (issue) begin
            wr_q    <= (wen_r != 4'd0);
            size_q  <= iss_size;
            addr_q  <= phys_addr;
            wdata_q <= wdata_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_rdata <= 32'd0;
        end else if (rdata_we) begin
            dc_rdata <= data_rdata;
        end
    end

    assign data_req        = (state == S_REQ);
    assign data_wr         = wr_q;
    assign data_size       = size_q;
    assign data_addr       = addr_q;
    assign data_wdata      = wdata_q;
    assign stallreq_for_dc = ((state == S_IDLE) && acc) || (state == S_REQ) || (state == S_WAIT);

endmodule

// File: tb/tb_dc_sram_like.sv
// tb/tb_dc_sram_like.sv - self-checking bench for dc_sram_like

module tb_dc_sram_like;

    localparam int WD = 250;

`ifdef DC_ADDR_MAP_EN
    localparam bit MAP = 1'b1;
`else
    localparam bit MAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, flush;
    logic [7:0]    stall;
    logic [WD-1:0] ex_to_dc_bus;
    logic          ex_mem_en;
    logic [3:0]    ex_mem_wen;
    logic [31:0]   ex_mem_addr, ex_mem_wdata;
    logic          ex_except;
    logic [WD-1:0] dc_to_mem_bus;
    logic [31:0]   dc_rdata;
    logic          stallreq_for_dc, data_req, data_wr;
    logic [1:0]    data_size;
    logic [31:0]   data_addr, data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [31:0]   data_rdata;

    always #5 clk = ~clk;

    dc_sram_like #(.DC_TO_MEM_WD(WD)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .stall           (stall),
        .ex_to_dc_bus    (ex_to_dc_bus),
        .ex_mem_en       (ex_mem_en),
        .ex_mem_wen      (ex_mem_wen),
        .ex_mem_addr     (ex_mem_addr),
        .ex_mem_wdata    (ex_mem_wdata),
        .ex_except       (ex_except),
        .dc_to_mem_bus   (dc_to_mem_bus),
        .dc_rdata        (dc_rdata),
        .stallreq_for_dc (stallreq_for_dc),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkbus(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lit(input logic [31:0] mapped, input logic [31:0] virt);
        return MAP ? mapped : virt;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    function automatic iss_t expect_issue(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd);
        iss_t r;
        logic [31:0] va;
        r.wr    = (wen != 4'd0);
        r.wdata = wd;
        if (!r.wr) begin
            r.size = 2'd2;
            va     = (a / 32'd4) * 32'd4;
        end else begin
            va = a;
            case ($countones(wen))
                1:       r.size = 2'd0;
                2:       r.size = 2'd1;
                default: r.size = 2'd2;
            endcase
        end
        if (MAP && va >= 32'h8000_0000 && va < 32'hA000_0000)      r.addr = va - 32'h8000_0000;
        else if (MAP && va >= 32'hA000_0000 && va < 32'hC000_0000) r.addr = va - 32'hA000_0000;
        else                                                       r.addr = va;
        return r;
    endfunction

    logic [WD-1:0] m_bus;
    logic          m_en, m_exc;
    logic [3:0]    m_wen;
    logic [31:0]   m_addr, m_wdata, m_rdata;
    logic          m_keep = 1'b0;

    always @(posedge clk) begin
        if (rst || flush || (stall[5] && !stall[6])) begin
            m_bus <= '0; m_en <= 1'b0; m_exc <= 1'b0; m_wen <= 4'd0; m_addr <= 32'd0; m_wdata <= 32'd0;
        end else if (!stall[5]) begin
            m_bus <= ex_to_dc_bus; m_en <= ex_mem_en; m_exc <= ex_except;
            m_wen <= ex_mem_wen; m_addr <= ex_mem_addr; m_wdata <= ex_mem_wdata;
        end
        if (rst) m_rdata <= 32'd0;
        else if (data_data_ok && m_keep) m_rdata <= data_rdata;
    end

    // ---------------- per-cycle compare ----------------
    logic        chk_on = 1'b0;
    iss_t        exp_iss = '0;
    logic        prev_req = 1'b0, prev_aok = 1'b0, prev_rst = 1'b1;
    logic        s_en = 1'b0, s_exc = 1'b0;
    logic [3:0]  s_wen = 4'd0;
    logic [31:0] s_addr = 32'd0, s_wdata = 32'd0;

    always @(negedge clk) begin
        if (chk_on) begin
            chkbus("dc_to_mem_bus", dc_to_mem_bus, m_bus);
            chk32("dc_rdata_model", dc_rdata, m_rdata);
            if (data_req) begin
                if (!prev_req) begin
                    chk1("issue_from_valid_access", s_en && !s_exc, 1'b1);
                    exp_iss = expect_issue(s_wen, s_addr, s_wdata);
                end
                chk1("data_wr", data_wr, exp_iss.wr);
                chk32("data_size", {30'd0, data_size}, {30'd0, exp_iss.size});
                chk32("data_addr", data_addr, exp_iss.addr);
                chk32("data_wdata", data_wdata, exp_iss.wdata);
            end
            if (prev_req && !data_req && !prev_rst) chk1("req_not_withdrawn", prev_aok, 1'b1);
        end
        prev_req = data_req; prev_aok = data_addr_ok; prev_rst = rst;
        s_en = m_en; s_exc = m_exc; s_wen = m_wen; s_addr = m_addr; s_wdata = m_wdata;
    end

    // ---------------- stimulus helpers ----------------
    logic auto_stall = 1'b1;

    // Advance one cycle; returns at the following negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_stall) stall = stallreq_for_dc ? 8'h60 : 8'h00;
        @(negedge clk);
    endtask

    task automatic present(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd, input logic exc);
        ex_mem_en = 1'b1; ex_mem_wen = wen; ex_mem_addr = a; ex_mem_wdata = wd; ex_except = exc;
        ex_to_dc_bus = '0;
        ex_to_dc_bus[249:218] = a;
        ex_to_dc_bus[31:0] = wd ^ 32'hC0FF_EE00;
        cyc();
        ex_mem_en = 1'b0; ex_mem_wen = 4'd0; ex_mem_addr = 32'd0; ex_mem_wdata = 32'd0; ex_except = 1'b0;
        ex_to_dc_bus = '0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!data_req && n < 10) begin
            cyc();
            n++;
        end
        chk1("req_seen", data_req, 1'b1);
    endtask

    task automatic run_access(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int addr_wait, input int data_wait,
                              input logic [1:0] exp_size, input logic [31:0] exp_addr,
                              input logic [31:0] exp_rd_after);
        int n;
        present(wen, a, wd, 1'b0);
        chk1("stallreq_on_entry", stallreq_for_dc, 1'b1);
        wait_req(n);
        chk32("issue_latency", n, 32'd1);
        chk32("lit_size", {30'd0, data_size}, {30'd0, exp_size});
        chk32("lit_addr", data_addr, exp_addr);
        chk1("lit_wr", data_wr, wen != 4'd0);
        for (int i = 0; i < addr_wait; i++) begin
            cyc();
            chk1("req_held", data_req, 1'b1);
        end
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        chk1("req_dropped_after_accept", data_req, 1'b0);
        chk1("stallreq_wait", stallreq_for_dc, 1'b1);
        for (int i = 1; i < data_wait; i++) begin
            cyc();
            chk1("stallreq_wait", stallreq_for_dc, 1'b1);
        end
        data_data_ok = 1'b1; data_rdata = rd; m_keep = (wen == 4'd0);
        cyc();
        data_data_ok = 1'b0; data_rdata = 32'h5A5A_5A5A; m_keep = 1'b0;
        chk1("stallreq_done", stallreq_for_dc, 1'b0);
        chk32("lit_rdata", dc_rdata, exp_rd_after);
        cyc();
        chk1("idle_no_req", data_req, 1'b0);
        chk1("idle_no_stall", stallreq_for_dc, 1'b0);
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; stall = 8'h00; ex_to_dc_bus = '0;
        ex_mem_en = 1'b0; ex_mem_wen = 4'd0; ex_mem_addr = 32'd0; ex_mem_wdata = 32'd0; ex_except = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        repeat (3) cyc();

        // reset state
        chk1("rst_req", data_req, 1'b0);
        chk1("rst_wr", data_wr, 1'b0);
        chk32("rst_size", {30'd0, data_size}, 32'd0);
        chk32("rst_addr", data_addr, 32'd0);
        chk32("rst_wdata", data_wdata, 32'd0);
        chk32("rst_rdata", dc_rdata, 32'd0);
        chkbus("rst_bus", dc_to_mem_bus, '0);
        chk1("rst_stallreq", stallreq_for_dc, 1'b0);
        rst = 1'b0;
        chk_on = 1'b1;
        cyc();

        // lw, addr_ok at once, data_ok three cycles later
        run_access(4'b0000, 32'h8000_0104, 32'd0, 32'hDEAD_BEEF, 0, 3, 2'd2,
                   lit(32'h0000_0104, 32'h8000_0104), 32'hDEAD_BEEF);
        // unaligned lw in kuseg, minimum latency
        run_access(4'b0000, 32'h0040_0006, 32'd0, 32'h0BAD_F00D, 0, 1, 2'd2,
                   32'h0040_0004, 32'h0BAD_F00D);
        // sb: dc_rdata must not change
        run_access(4'b0100, 32'hA000_0013, 32'h00AB_0000, 32'h5555_5555, 0, 1, 2'd0,
                   lit(32'h0000_0013, 32'hA000_0013), 32'h0BAD_F00D);
        // sh with delayed accept
        run_access(4'b1100, 32'h8000_0022, 32'h1234_0000, 32'h6666_6666, 2, 2, 2'd1,
                   lit(32'h0000_0022, 32'h8000_0022), 32'h0BAD_F00D);
        // sw at the top of kseg0 and in kseg2
        run_access(4'b1111, 32'h9FFF_FFFC, 32'hCAFE_F00D, 32'h7777_7777, 0, 1, 2'd2,
                   lit(32'h1FFF_FFFC, 32'h9FFF_FFFC), 32'h0BAD_F00D);
        run_access(4'b1111, 32'hC000_0010, 32'h0102_0304, 32'h7777_7777, 1, 1, 2'd2,
                   32'hC000_0010, 32'h0BAD_F00D);

        // exception-flagged access is suppressed
        present(4'b0000, 32'h8000_0104, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk1("except_no_req", data_req, 1'b0);
            chk1("except_no_stall", stallreq_for_dc, 1'b0);
            cyc();
        end

        // flush in WAIT, new lw enters while the old response drains
        present(4'b0000, 32'h8000_0200, 32'd0, 1'b0);
        wait_req(n);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk1("drain_stall", stallreq_for_dc, 1'b1);
        auto_stall = 1'b0; stall = 8'h00;
        present(4'b0000, 32'h8000_0300, 32'd0, 1'b0);
        stall = 8'h60; auto_stall = 1'b1;
        chk1("drain_no_new_req", data_req, 1'b0);
        chk1("drain_new_stall", stallreq_for_dc, 1'b1);
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111; m_keep = 1'b0;
        cyc();
        data_data_ok = 1'b0;
        chk1("drain_done_no_req", data_req, 1'b0);
        chk1("drain_done_stall", stallreq_for_dc, 1'b1);
        chk32("drain_discarded", dc_rdata, 32'h0BAD_F00D);
        cyc();
        chk1("new_req_after_drain", data_req, 1'b1);
        chk32("new_req_addr", data_addr, lit(32'h0000_0300, 32'h8000_0300));
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h2222_2222; m_keep = 1'b1;
        cyc();
        data_data_ok = 1'b0; m_keep = 1'b0;
        chk32("new_rdata", dc_rdata, 32'h2222_2222);
        chk1("new_done_stall", stallreq_for_dc, 1'b0);
        cyc();

        // addr_ok held low five cycles, flush in the second
        present(4'b0000, 32'h8000_0400, 32'd0, 1'b0);
        wait_req(n);
        for (int c = 1; c <= 5; c++) begin
            chk1("hold_req", data_req, 1'b1);
            chk32("hold_addr", data_addr, lit(32'h0000_0400, 32'h8000_0400));
            flush = (c == 2);
            cyc();
        end
        flush = 1'b0;
        chk1("hold_req_still", data_req, 1'b1);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h3333_3333; m_keep = 1'b0;
        cyc();
        data_data_ok = 1'b0;
        chk32("cancel_discarded", dc_rdata, 32'h2222_2222);
        chk1("cancel_idle_stall", stallreq_for_dc, 1'b0);
        chk1("cancel_idle_req", data_req, 1'b0);
        cyc();

        // DONE held by stall[6] for four cycles
        present(4'b0000, 32'h8000_0500, 32'd0, 1'b0);
        wait_req(n);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h4444_4444; m_keep = 1'b1;
        auto_stall = 1'b0;
        cyc();
        data_data_ok = 1'b0; m_keep = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("done_hold_stall", stallreq_for_dc, 1'b0);
            chk1("done_hold_req", data_req, 1'b0);
            chk32("done_hold_rdata", dc_rdata, 32'h4444_4444);
            cyc();
        end
        stall = 8'h00;
        cyc();
        auto_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk1("release_no_reissue", data_req, 1'b0);
            chk1("release_no_stall", stallreq_for_dc, 1'b0);
            cyc();
        end

        // reset in WAIT; the late response is ignored
        present(4'b0000, 32'h8000_0600, 32'd0, 1'b0);
        wait_req(n);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h6666_6666; m_keep = 1'b0;
        cyc();
        data_data_ok = 1'b0;
        chk32("rst_mid_rdata", dc_rdata, 32'd0);
        chk1("rst_mid_req", data_req, 1'b0);
        chk1("rst_mid_stall", stallreq_for_dc, 1'b0);
        cyc();

        run_access(4'b0000, 32'h8000_0700, 32'd0, 32'h7070_7070, 0, 1, 2'd2,
                   lit(32'h0000_0700, 32'h8000_0700), 32'h7070_7070);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
